// File: rtl/cybernid_feature_packer_if.sv
// Bus bundle for the cybernid feature packer: raw feature stream in,
// threshold programming port, packed layer-0 vector out, plus status.
// The master modport is the packer's view; slave is the environment's view.
interface cybernid_feature_packer_if #(
    parameter int NUM_FEATURES = 3,
    parameter int FEAT_W       = 8,
    parameter int Q_W          = 2,
    parameter int CNT_W        = 16
);
    logic                        s_valid;
    logic                        s_ready;
    logic [FEAT_W-1:0]           s_data;
    logic                        s_last;

    logic                        thr_we;
    logic [Q_W-1:0]              thr_sel;
    logic [FEAT_W-1:0]           thr_data;

    logic                        m_valid;
    logic                        m_ready;
    logic [NUM_FEATURES*Q_W-1:0] m_data;

    logic                        err_frame;
    logic [CNT_W-1:0]            sample_cnt;

    modport master (
        input  s_valid, s_data, s_last, thr_we, thr_sel, thr_data, m_ready,
        output s_ready, m_valid, m_data, err_frame, sample_cnt
    );

    modport slave (
        output s_valid, s_data, s_last, thr_we, thr_sel, thr_data, m_ready,
        input  s_ready, m_valid, m_data, err_frame, sample_cnt
    );
endinterface

// File: rtl/cybernid_feature_packer.sv
// cybernid_feature_packer: quantizes raw feature beats against a programmable
// threshold table and packs NUM_FEATURES codes into the flat vector that the
// layer-0 LUT neurons slice (feature i at bits [i*Q_W +: Q_W]).
// Optional macro CYBERNID_PACKER_PINGPONG_EN: the assembly register doubles as
// a second buffer so the next sample can fill while the current vector waits.
module cybernid_feature_packer #(
    parameter int NUM_FEATURES = 3,
    parameter int FEAT_W       = 8,
    parameter int Q_W          = 2,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    cybernid_feature_packer_if.master bus
);
    localparam int NUM_THR = (1 << Q_W) - 1;
    localparam int VEC_W   = NUM_FEATURES * Q_W;
    localparam int IDX_W   = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

`ifdef CYBERNID_PACKER_PINGPONG_EN
    localparam bit PINGPONG = 1'b1;
`else
    localparam bit PINGPONG = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_FILL,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [VEC_W-1:0]  asm_q, asm_d;
    logic              pend_q, pend_d;
    logic              m_valid_q, m_valid_d;
    logic [VEC_W-1:0]  m_data_q, m_data_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FEAT_W-1:0] thr_q [NUM_THR];
    logic [FEAT_W-1:0] thr_d [NUM_THR];

    logic [Q_W-1:0]    q_code;
    logic [VEC_W-1:0]  beat_vec;
    logic              s_ready;
    logic              out_free;
    logic              last_slot;

    // Quantizer: code is the number of thresholds the raw feature reaches.
    always_comb begin
        q_code = '0;
        for (int k = 0; k < NUM_THR; k++) begin
            if (bus.s_data >= thr_q[k]) q_code = q_code + Q_W'(1);
        end
    end

    // Threshold table update; the top index has no entry and is ignored.
    always_comb begin
        thr_d = thr_q;
        if (bus.thr_we) begin
            for (int k = 0; k < NUM_THR; k++) begin
                if (bus.thr_sel == Q_W'(k)) thr_d[k] = bus.thr_data;
            end
        end
    end

    // Assembly register with the current beat's code dropped into slot idx.
    always_comb begin
        beat_vec = asm_q;
        for (int i = 0; i < NUM_FEATURES; i++) begin
            if (idx_q == IDX_W'(i)) beat_vec[i*Q_W +: Q_W] = q_code;
        end
    end

    // Framing FSM, output handshake and sample counting.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        pend_d    = pend_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        s_ready   = 1'b1;
        last_slot = (idx_q == IDX_W'(NUM_FEATURES - 1));
        out_free  = !m_valid_q || bus.m_ready;

        // Vector delivered: either retire it or promote the parked buffer.
        if (m_valid_q && bus.m_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (pend_q) begin
                m_data_d = asm_q;
                asm_d    = '0;
                pend_d   = 1'b0;
            end else begin
                m_valid_d = 1'b0;
            end
        end

        case (state_q)
            ST_FILL: begin
                if (bus.s_valid) begin
                    if (last_slot || bus.s_last) begin
                        idx_d = '0;
                        err_d = !(last_slot && bus.s_last);
                        if (out_free || !PINGPONG) begin
                            m_data_d  = beat_vec;
                            m_valid_d = 1'b1;
                            asm_d     = '0;
                        end else begin
                            asm_d  = beat_vec;
                            pend_d = 1'b1;
                        end
                        if (!bus.s_last) begin
                            state_d = ST_DRAIN;
                        end else if (!PINGPONG || !out_free) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        asm_d = beat_vec;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.s_valid && bus.s_last) begin
                    state_d = (PINGPONG ? pend_d : m_valid_d) ? ST_HOLD : ST_FILL;
                end
            end
            ST_HOLD: begin
                s_ready = 1'b0;
                if (m_valid_q && bus.m_ready) state_d = ST_FILL;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: state uses non-blocking assignments so every flop samples
            // the pre-edge values regardless of statement order.
            state_q   <= ST_FILL;
            idx_q     <= '0;
            asm_q     <= '0;
            pend_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            asm_q     <= asm_d;
            pend_q    <= pend_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Threshold table registers, restored to evenly spaced defaults.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this table is small and must come up with usable defaults,
            // so it is built from resettable flops rather than a RAM.
            for (int k = 0; k < NUM_THR; k++) begin
                thr_q[k] <= FEAT_W'((k + 1) << (FEAT_W - Q_W));
            end
        end else begin
            thr_q <= thr_d;
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.err_frame  = err_q;
    assign bus.sample_cnt = cnt_q;

endmodule

// File: tb/tb_cybernid_feature_packer.sv
// Self-checking bench for cybernid_feature_packer. A monitor keeps a
// sample-level model (thresholds, partial codes, queue of undelivered
// vectors) and compares every DUT output each cycle; directed sequences pin
// hand-computed vectors, then randomized traffic runs against the model.
module tb_cybernid_feature_packer;
    localparam int NF = 3;
    localparam int FW = 8;
    localparam int QW = 2;
    localparam int CW = 16;
    localparam int NT = 3;
`ifdef CYBERNID_PACKER_PINGPONG_EN
    localparam int CAP        = 2;
    localparam bit HOLD_READY = 1'b1;
`else
    localparam int CAP        = 1;
    localparam bit HOLD_READY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    cybernid_feature_packer_if #(
        .NUM_FEATURES(NF), .FEAT_W(FW), .Q_W(QW), .CNT_W(CW)
    ) bus ();

    cybernid_feature_packer #(
        .NUM_FEATURES(NF), .FEAT_W(FW), .Q_W(QW), .CNT_W(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [FW-1:0] thr_m [NT];
    int            codes[$];
    logic [5:0]    exp_q[$];
    bit            dropping;
    bit            err_next;
    int            hs_count;

    function automatic int quant(input logic [FW-1:0] d);
        int n = 0;
        for (int k = 0; k < NT; k++) if (d >= thr_m[k]) n++;
        return n;
    endfunction

    task automatic model_reset();
        thr_m[0] = 8'd64; thr_m[1] = 8'd128; thr_m[2] = 8'd192;
        codes.delete();
        exp_q.delete();
        dropping = 1'b0;
        err_next = 1'b0;
        hs_count = 0;
    endtask

    // Monitor: compare at every falling edge, then advance the model with the
    // transfers that the next rising edge will perform.
    initial begin
        bit         ready_m;
        logic [5:0] vec;
        int         q;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) begin
                model_reset();
            end else begin
                ready_m = !(exp_q.size() >= CAP && !dropping);
                check("m_valid", bus.m_valid, exp_q.size() > 0);
                if (exp_q.size() > 0) check("m_data", bus.m_data, exp_q[0]);
                check("s_ready", bus.s_ready, ready_m);
                check("err_frame", bus.err_frame, err_next);
                check("sample_cnt", bus.sample_cnt, hs_count & 16'hFFFF);
                err_next = 1'b0;
                if (exp_q.size() > 0 && bus.m_ready === 1'b1) begin
                    void'(exp_q.pop_front());
                    hs_count++;
                end
                if (bus.s_valid && ready_m) begin
                    q = quant(bus.s_data);
                    if (dropping) begin
                        if (bus.s_last) dropping = 1'b0;
                    end else begin
                        codes.push_back(q);
                        if (bus.s_last || codes.size() == NF) begin
                            vec = '0;
                            foreach (codes[i]) vec = vec | 6'(codes[i] << (QW * i));
                            exp_q.push_back(vec);
                            err_next = !(bus.s_last && codes.size() == NF);
                            if (!bus.s_last) dropping = 1'b1;
                            codes.delete();
                        end
                    end
                end
                if (bus.thr_we && bus.thr_sel != 2'd3) thr_m[bus.thr_sel] = bus.thr_data;
            end
        end
    end

    // ---------------- stimulus ----------------
    bit mr_fixed = 1'b1;
    bit mr_rand  = 1'b0;

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.m_ready = mr_rand ? 1'($urandom_range(0, 1)) : mr_fixed;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat from just after a rising edge and hold until accepted.
    task automatic send_beat(input logic [FW-1:0] d, input bit last);
        int guard = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        @(negedge clk);
        while (!bus.s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("beat_accept_timeout", 64'd0, 64'd1);
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // Wait (bounded) at falling edges for m_valid and pin the vector value.
    task automatic wait_vec(input string name, input logic [5:0] exp_data, output int lat);
        lat = 0;
        @(negedge clk);
        while (!bus.m_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_valid"}, bus.m_valid, 64'd1);
        check({name, "_data"}, bus.m_data, exp_data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
        bus.thr_we = 1'b0;  bus.thr_sel = '0; bus.thr_data = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", bus.m_valid, 64'd0);
        check("rst_m_data", bus.m_data, 64'd0);
        check("rst_s_ready", bus.s_ready, 64'd1);
        check("rst_sample_cnt", bus.sample_cnt, 64'd0);
        check("rst_err", bus.err_frame, 64'd0);
        rst = 1'b1;
        tick(); tick();

        // Default thresholds 64/128/192: codes 0,2,3.
        send_beat(8'd10, 1'b0); send_beat(8'd130, 1'b0); send_beat(8'd250, 1'b1);
        wait_vec("t1", 6'b111000, lat);
        check("t1_latency", lat, 64'd0);
        @(negedge clk);
        check("t1_cnt", bus.sample_cnt, 64'd1);
        tick();

        // Lower threshold 0 to 5: codes 0,1,3.
        bus.thr_we = 1'b1; bus.thr_sel = 2'd0; bus.thr_data = 8'd5;
        tick();
        bus.thr_we = 1'b0;
        send_beat(8'd4, 1'b0); send_beat(8'd5, 1'b0); send_beat(8'd255, 1'b1);
        wait_vec("t2", 6'b110100, lat);
        tick();

        // Short sample, zero-filled, with framing error.
        send_beat(8'd200, 1'b0); send_beat(8'd70, 1'b1);
        wait_vec("t3", 6'b000111, lat);
        check("t3_err", bus.err_frame, 64'd1);
        tick();
        send_beat(8'd0, 1'b0); send_beat(8'd64, 1'b0); send_beat(8'd128, 1'b1);
        wait_vec("t3b", 6'b100100, lat);
        check("t3b_err", bus.err_frame, 64'd0);
        tick();

        // Overlong sample: extras up to s_last are dropped.
        send_beat(8'd255, 1'b0); send_beat(8'd255, 1'b0); send_beat(8'd255, 1'b0);
        wait_vec("t4", 6'b111111, lat);
        check("t4_err", bus.err_frame, 64'd1);
        tick();
        send_beat(8'd1, 1'b0); send_beat(8'd2, 1'b1);
        send_beat(8'd10, 1'b0); send_beat(8'd130, 1'b0); send_beat(8'd250, 1'b1);
        wait_vec("t4b", 6'b111001, lat);
        check("t4b_cnt", bus.sample_cnt, 64'd5);
        tick();

        // Back-pressure: vector and data held stable.
        mr_fixed = 1'b0;
        tick(); tick();
        send_beat(8'd128, 1'b0); send_beat(8'd128, 1'b0); send_beat(8'd128, 1'b1);
        wait_vec("t5", 6'b101010, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_hold_valid", bus.m_valid, 64'd1);
            check("t5_hold_data", bus.m_data, 64'b101010);
            check("t5_hold_ready", bus.s_ready, HOLD_READY);
        end
        tick();
`ifdef CYBERNID_PACKER_PINGPONG_EN
        send_beat(8'd0, 1'b0); send_beat(8'd0, 1'b0); send_beat(8'd0, 1'b1);
        @(negedge clk);
        check("t5_pp_stall", bus.s_ready, 64'd0);
        check("t5_pp_data", bus.m_data, 64'b101010);
        tick();
`endif
        mr_fixed = 1'b1;
        repeat (4) tick();
        check("t5_drained", bus.m_valid, 64'd0);

        // Reset with a pending vector and a partial sample.
        mr_fixed = 1'b0;
        tick(); tick();
        send_beat(8'd200, 1'b0); send_beat(8'd200, 1'b0); send_beat(8'd200, 1'b1);
`ifdef CYBERNID_PACKER_PINGPONG_EN
        send_beat(8'd200, 1'b0); send_beat(8'd200, 1'b0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", bus.m_valid, 64'd0);
        check("t6_rst_cnt", bus.sample_cnt, 64'd0);
        check("t6_rst_data", bus.m_data, 64'd0);
        check("t6_rst_ready", bus.s_ready, 64'd1);
        tick();
        rst = 1'b1;
        mr_fixed = 1'b1;
        tick(); tick();
        send_beat(8'd0, 1'b0); send_beat(8'd0, 1'b0); send_beat(8'd0, 1'b1);
        wait_vec("t6", 6'b000000, lat);
        tick();
        send_beat(8'd32, 1'b0); send_beat(8'd64, 1'b0); send_beat(8'd200, 1'b1);
        wait_vec("t6_thr_default", 6'b110100, lat);
        tick();

        // Randomized traffic against the model.
        mr_rand = 1'b1;
        for (int s = 0; s < 300; s++) begin
            int len;
            len = $urandom_range(1, NF + 2);
            for (int b = 0; b < len; b++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        bus.thr_we   = 1'b1;
                        bus.thr_sel  = 2'($urandom_range(0, 3));
                        bus.thr_data = 8'($urandom);
                    end
                    tick();
                    bus.thr_we = 1'b0;
                end
                if ($urandom_range(0, 15) == 0) begin
                    bus.thr_we   = 1'b1;
                    bus.thr_sel  = 2'($urandom_range(0, 3));
                    bus.thr_data = 8'($urandom);
                end
                send_beat(8'($urandom), (b == len - 1) ? ($urandom_range(0, 7) != 0) : 1'b0);
                bus.thr_we = 1'b0;
            end
        end
        mr_rand  = 1'b0;
        mr_fixed = 1'b1;
        repeat (10) tick();
        check("final_drained", exp_q.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
